// File: rtl/ac97_pkg.sv
// Shared constants for the AC97 codec-side link model: frame geometry,
// tag bit positions, codec register map, reset defaults and read-only masks.
package ac97_pkg;

  // Last bit index of a 256-bit frame and the last bit of each decoded slot.
  localparam logic [7:0] FRAME_LAST = 8'd255;
  localparam logic [7:0] TAG_END    = 8'd15;
  localparam logic [7:0] SLOT1_END  = 8'd35;
  localparam logic [7:0] SLOT2_END  = 8'd55;
  localparam logic [7:0] SLOT3_END  = 8'd75;
  localparam logic [7:0] SLOT4_END  = 8'd95;

  // Tag, slot 1, slot 2, slot 3 and slot 4 form the first 96 bits of a frame.
  localparam int TX_LEN = 96;

  // Inbound tag bit positions.
  localparam int TAG_FRAME = 15;
  localparam int TAG_SLOT1 = 14;
  localparam int TAG_SLOT2 = 13;
  localparam int TAG_SLOT3 = 12;
  localparam int TAG_SLOT4 = 11;

  // Slot 1 command word: read flag above the 7-bit address.
  localparam int CMD_RD_BIT = 19;

  // Register file geometry: even addresses 0x00..0x7E.
  localparam int REG_COUNT = 64;

  // Register addresses with non-zero defaults or special write behaviour.
  localparam logic [6:0] ADDR_RESET      = 7'h00;
  localparam logic [6:0] ADDR_MASTER_VOL = 7'h02;
  localparam logic [6:0] ADDR_PCM_VOL    = 7'h18;
  localparam logic [6:0] ADDR_POWERDOWN  = 7'h26;
  localparam logic [6:0] ADDR_VENDOR_ID1 = 7'h7C;
  localparam logic [6:0] ADDR_VENDOR_ID2 = 7'h7E;

  // Reset defaults.
  localparam logic [15:0] DEF_RESET      = 16'h0090;
  localparam logic [15:0] DEF_MASTER_VOL = 16'h8000;
  localparam logic [15:0] DEF_PCM_VOL    = 16'h8808;
  localparam logic [15:0] DEF_POWERDOWN  = 16'h000F;
  localparam logic [15:0] DEF_VENDOR_ID1 = 16'h4144;
  localparam logic [15:0] DEF_VENDOR_ID2 = 16'h5370;

  // Power-down status nibble is owned by the codec, not the controller.
  localparam logic [15:0] RO_POWERDOWN = 16'h000F;
  localparam logic [15:0] RO_ALL       = 16'hFFFF;
  localparam logic [15:0] RO_NONE      = 16'h0000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_e;

  // Default value of the register at a byte address.
  function automatic logic [15:0] reg_default(input logic [6:0] addr);
    logic [15:0] val;
    case (addr)
      ADDR_RESET:      val = DEF_RESET;
      ADDR_MASTER_VOL: val = DEF_MASTER_VOL;
      ADDR_PCM_VOL:    val = DEF_PCM_VOL;
      ADDR_POWERDOWN:  val = DEF_POWERDOWN;
      ADDR_VENDOR_ID1: val = DEF_VENDOR_ID1;
      ADDR_VENDOR_ID2: val = DEF_VENDOR_ID2;
      default:         val = 16'h0000;
    endcase
    return val;
  endfunction

  // Bits a controller write cannot change at a byte address.
  function automatic logic [15:0] reg_ro_mask(input logic [6:0] addr);
    logic [15:0] mask;
    case (addr)
      ADDR_RESET:      mask = RO_ALL;
      ADDR_POWERDOWN:  mask = RO_POWERDOWN;
      ADDR_VENDOR_ID1: mask = RO_ALL;
      ADDR_VENDOR_ID2: mask = RO_ALL;
      default:         mask = RO_NONE;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ac97_codec_regs.sv
// Codec register file: 64 x 16 entries at even byte addresses, synchronous
// write with read-only masking, asynchronous read port. A write to address
// 0x00 restores every register to its default.
module ac97_codec_regs
  import ac97_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        i_we,
  input  logic [6:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [6:0]  i_raddr,
  output logic [15:0] o_rdata
);

  logic [15:0] r_mem [REG_COUNT];

  logic        w_srst;
  logic        w_wr_ok;
  logic [5:0]  w_widx;
  logic [15:0] w_mask;
  logic [15:0] w_wval;

  // Decode the write: soft reset on 0x00, odd addresses dropped, read-only bits kept.
  always_comb begin
    w_srst  = 1'b0;
    w_wr_ok = 1'b0;
    w_widx  = i_waddr[6:1];
    w_mask  = reg_ro_mask(i_waddr);
    w_wval  = (i_wdata & ~w_mask) | (r_mem[w_widx] & w_mask);
    if (i_we && (i_waddr == ADDR_RESET)) begin
      w_srst = 1'b1;
    end else if (i_we && !i_waddr[0]) begin
      w_wr_ok = 1'b1;
    end else begin
      w_wr_ok = 1'b0;
    end
  end

  // Read port: even addresses index the file, odd addresses return zero.
  always_comb begin
    if (i_raddr[0]) begin
      o_rdata = 16'h0000;
    end else begin
      o_rdata = r_mem[i_raddr[6:1]];
    end
  end

  // Register storage with async reset and synchronous restore-to-defaults.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_mem[i] <= reg_default({i[5:0], 1'b0});
      end
    end else if (w_srst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_mem[i] <= reg_default({i[5:0], 1'b0});
      end
    end else if (w_wr_ok) begin
      r_mem[w_widx] <= w_wval;
    end
  end

endmodule

// File: rtl/ac97_codec_model.sv
// AC97 codec-side link responder: tracks frame position from sync, decodes
// register commands and PCM slots from sdata_out, and serializes the status
// and ADC frame back on sdata_in one bit clock behind the inbound bit.
module ac97_codec_model
  import ac97_pkg::*;
#(
  parameter int READY_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        sync,
  input  logic        sdata_out,
  output logic        sdata_in,
  input  logic [19:0] adc_left,
  input  logic [19:0] adc_right,
  output logic        codec_ready,
  output logic        pcm_valid,
  output logic [19:0] pcm_left,
  output logic [19:0] pcm_right,
  output logic        frame_err
);

  frame_state_e r_state;
  logic         r_sync_q;
  logic [7:0]   r_bit;        // index of the bit sampled on the next clock while in FRAME
  logic [18:0]  r_sh;         // most recent inbound bits, oldest first
  logic [15:11] r_tag;        // decoded tag valid bits of the current frame
  logic [19:12] r_cmd;        // read flag and address of the current slot 1
  logic [19:0]  r_slot3;
  logic [TX_LEN-1:0] r_tx;    // outbound tag and slots 1..4, latched at b=0
  logic         r_rd_pend;
  logic [6:0]   r_rd_addr;
  logic [7:0]   r_frame_cnt;
  logic         r_ready;
  logic         r_sdata_in;
  logic         r_pcm_valid;
  logic [19:0]  r_pcm_left;
  logic [19:0]  r_pcm_right;
  logic         r_frame_err;

  logic         w_sync_edge;
  logic         w_active;
  logic [7:0]   w_b;
  logic [19:0]  w_word;
  logic         w_cmd_ok;
  logic         w_wr_en;
  logic         w_rd_accept;
  logic         w_pcm_take;
  logic [15:0]  w_rd_data;
  logic [15:0]  w_tag_out;
  logic [19:0]  w_s1_out;
  logic [19:0]  w_s2_out;
  logic [TX_LEN-1:0] w_tx_vec;
  logic [6:0]   w_tx_idx;
  logic         w_tx_bit;

  ac97_codec_regs u_regs (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_we    (w_wr_en),
    .i_waddr (r_cmd[18:12]),
    .i_wdata (w_word[19:4]),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Current bit position and the slot word completed by the bit sampled now.
  always_comb begin
    w_sync_edge = sync & ~r_sync_q;
    w_active    = w_sync_edge | (r_state == ST_FRAME);
    if (w_sync_edge) begin
      w_b = 8'd0;
    end else begin
      w_b = r_bit;
    end
    w_word = {r_sh, sdata_out};
  end

  // Command and PCM decode; commands only count once the codec is ready.
  always_comb begin
    w_cmd_ok    = r_ready & r_tag[TAG_FRAME] & r_tag[TAG_SLOT1];
    w_wr_en     = 1'b0;
    w_rd_accept = 1'b0;
    w_pcm_take  = 1'b0;
    if (w_active && (w_b == SLOT2_END) && w_cmd_ok) begin
      w_wr_en     = ~r_cmd[CMD_RD_BIT] & r_tag[TAG_SLOT2];
      w_rd_accept = r_cmd[CMD_RD_BIT];
    end else if (w_active && (w_b == SLOT4_END)) begin
      w_pcm_take  = r_tag[TAG_FRAME] & r_tag[TAG_SLOT3] & r_tag[TAG_SLOT4];
    end else begin
      w_wr_en     = 1'b0;
    end
  end

  // Outbound frame: a pending read response replaces the slot-valid bits.
  always_comb begin
    if (r_rd_pend) begin
      w_tag_out = {r_ready, 1'b1, 1'b1, 13'd0};
      w_s1_out  = {1'b0, r_rd_addr, 12'd0};
      w_s2_out  = {w_rd_data, 4'd0};
    end else begin
      w_tag_out = {r_ready, 2'b00, r_ready, r_ready, 11'd0};
      w_s1_out  = 20'd0;
      w_s2_out  = 20'd0;
    end
    w_tx_vec = {w_tag_out, w_s1_out, w_s2_out, adc_left, adc_right};
  end

  // Pick the outbound bit for the current index; b=0 uses the frame being latched.
  always_comb begin
    w_tx_idx = 7'(8'd95 - w_b);
    if (!w_active) begin
      w_tx_bit = 1'b0;
    end else if (w_b == 8'd0) begin
      w_tx_bit = w_tx_vec[TX_LEN-1];
    end else if (w_b <= SLOT4_END) begin
      w_tx_bit = r_tx[w_tx_idx];
    end else begin
      w_tx_bit = 1'b0;
    end
  end

  // Frame sequencer, inbound capture, read/PCM bookkeeping and outbound serializer.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= ST_IDLE;
      r_sync_q    <= 1'b0;
      r_bit       <= 8'd0;
      r_sh        <= 19'd0;
      r_tag       <= 5'd0;
      r_cmd       <= 8'd0;
      r_slot3     <= 20'd0;
      r_tx        <= {TX_LEN{1'b0}};
      r_rd_pend   <= 1'b0;
      r_rd_addr   <= 7'd0;
      r_frame_cnt <= 8'd0;
      r_ready     <= 1'b0;
      r_sdata_in  <= 1'b0;
      r_pcm_valid <= 1'b0;
      r_pcm_left  <= 20'd0;
      r_pcm_right <= 20'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync_q    <= sync;
      r_sdata_in  <= w_tx_bit;
      r_pcm_valid <= 1'b0;

      if (w_sync_edge) begin
        // An edge while still inside a frame truncates it; its uncommitted data is lost.
        if (r_state == ST_FRAME) begin
          r_frame_err <= 1'b1;
        end
        r_state <= ST_FRAME;
        r_bit   <= 8'd1;
      end else if (r_state == ST_FRAME) begin
        if (r_bit == FRAME_LAST) begin
          r_state <= ST_IDLE;
          r_bit   <= 8'd0;
          if (!r_ready) begin
            if (r_frame_cnt >= 8'(READY_FRAMES - 1)) begin
              r_ready <= 1'b1;
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end else begin
          r_bit <= r_bit + 8'd1;
        end
      end else begin
        r_state <= ST_IDLE;
        r_bit   <= 8'd0;
      end

      if (w_active) begin
        r_sh <= w_word[18:0];
        case (w_b)
          8'd0: begin
            r_tx      <= w_tx_vec;
            r_rd_pend <= 1'b0;
          end
          TAG_END: begin
            r_tag <= w_word[15:11];
          end
          SLOT1_END: begin
            r_cmd <= w_word[19:12];
          end
          SLOT2_END: begin
            if (w_rd_accept) begin
              r_rd_pend <= 1'b1;
              r_rd_addr <= r_cmd[18:12];
            end
          end
          SLOT3_END: begin
            r_slot3 <= w_word;
          end
          SLOT4_END: begin
            if (w_pcm_take) begin
              r_pcm_left  <= r_slot3;
              r_pcm_right <= w_word;
              r_pcm_valid <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sdata_in    = r_sdata_in;
  assign codec_ready = r_ready;
  assign pcm_valid   = r_pcm_valid;
  assign pcm_left    = r_pcm_left;
  assign pcm_right   = r_pcm_right;
  assign frame_err   = r_frame_err;

endmodule
